// File: rtl/er2_pkg.sv
// er2_pkg: command encodings, FSM states and DR sizing shared by the ER2 slot controller
package er2_pkg;
    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_CLR = 2'b11;
    typedef enum logic {IDLE, WAIT} state_t;
    function automatic int dr_width(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction
endpackage

// File: rtl/er2_shift_reg.sv
// er2_shift_reg: ER2 data register with capture, LSB-first shift and TDO, gated by slot select
module er2_shift_reg #(
    parameter int N = 42
) (
    input  logic         JTCK,
    input  logic         JRSTN,
    input  logic         i_sel,
    input  logic         i_shift,
    input  logic         i_update,
    input  logic         i_tdi,
    input  logic [N-1:0] i_cap,
    output logic [N-1:0] o_sr,
    output logic         o_tdo
);
    logic [N-1:0] r_sr;
    always_ff @(posedge JTCK) begin
        if (!JRSTN)
            r_sr <= '0;
        else if (i_sel && i_shift)
            r_sr <= {i_tdi, r_sr[N-1:1]};
        else if (i_sel && !i_update)
            r_sr <= i_cap;
    end
    assign o_sr  = r_sr;
    assign o_tdo = r_sr[0];
endmodule

// File: rtl/er2_cmd_ctrl.sv
// er2_cmd_ctrl: ER2 slot controller turning updated DR words into req/ack register-bus transactions
module er2_cmd_ctrl import er2_pkg::*; #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              JTCK,
    input  logic              JRSTN,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE2,
    input  logic              IP_ENABLE,
    output logic              ER2_TDO,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ack,
    output logic              busy,
    output logic              err
);
    localparam int N  = dr_width(ADDR_W, DATA_W);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    state_t            r_state;
    logic              r_req, r_we, r_busy, r_err, r_ovr;
    logic [ADDR_W-1:0] r_addr, r_last_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [TW-1:0]     r_tmo;
    logic [N-1:0]      w_sr;
    logic [1:0]        w_cmd;
    logic              w_sel, w_upd, w_go, w_clr, w_err;
    assign w_sel = JCE2 & IP_ENABLE;
    assign w_cmd = w_sr[1:0];
    assign w_upd = w_sel & JUPDATE;
    assign w_go  = w_upd & (w_cmd == CMD_WR || w_cmd == CMD_RD);
    assign w_clr = w_upd & (w_cmd == CMD_CLR);
    assign w_err = r_err | r_ovr;
    er2_shift_reg #(.N(N)) u_sr (
        .JTCK     (JTCK),
        .JRSTN    (JRSTN),
        .i_sel    (w_sel),
        .i_shift  (JSHIFT),
        .i_update (JUPDATE),
        .i_tdi    (JTDI),
        .i_cap    ({r_rdata, r_last_addr, w_err, r_busy}),
        .o_sr     (w_sr),
        .o_tdo    (ER2_TDO)
    );
    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_ovr       <= 1'b0;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_tmo       <= '0;
        end else begin
            if (w_clr) begin
                r_err <= 1'b0;
                r_ovr <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (w_go) begin
                    r_state     <= WAIT;
                    r_req       <= 1'b1;
                    r_busy      <= 1'b1;
                    r_we        <= (w_cmd == CMD_WR);
                    r_addr      <= w_sr[ADDR_W+1:2];
                    r_last_addr <= w_sr[ADDR_W+1:2];
                    r_wdata     <= w_sr[N-1:ADDR_W+2];
                    r_tmo       <= TW'(ACK_TIMEOUT);
                end
            end else begin
                // a second start while busy is refused and flagged; the live transaction is untouched
                if (w_go) begin
                    r_err <= 1'b1;
                    r_ovr <= 1'b1;
                end
                if (ack) begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    if (!r_we)
                        r_rdata <= rdata;
                end else if (r_tmo == '0) begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                end else begin
                    r_tmo <= r_tmo - TW'(1);
                end
            end
        end
    end
    assign req   = r_req;
    assign we    = r_we;
    assign addr  = r_addr;
    assign wdata = r_wdata;
    assign busy  = r_busy;
    assign err   = w_err;
endmodule

// File: tb/tb_er2_cmd_ctrl.sv
// tb_er2_cmd_ctrl: randomized transaction-level checks of the ER2 slot controller against a reference model
module tb_er2_cmd_ctrl;
    import er2_pkg::*;
    logic        JTCK = 0, JRSTN = 0, JTDI = 0, JSHIFT = 0, JUPDATE = 0, JCE2 = 0, IP_ENABLE = 0, ack = 0;
    logic [31:0] rdata = '0;
    logic        ER2_TDO, req, we, busy, err;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          n_tot = 0, n_pass = 0;
    logic        m_err = 0;
    logic [7:0]  m_last = '0;
    logic [31:0] m_rdata = '0;
    er2_cmd_ctrl dut (
        .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
        .JCE2(JCE2), .IP_ENABLE(IP_ENABLE), .ER2_TDO(ER2_TDO), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
    );
    always #5 JTCK = ~JTCK;
    task automatic tick();
        @(negedge JTCK);
    endtask
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask
    task automatic scan(input logic [41:0] din, output logic [41:0] dout);
        JCE2 = 1; IP_ENABLE = 1; JSHIFT = 0; JUPDATE = 0;
        tick();
        JSHIFT = 1;
        for (int i = 0; i < 42; i++) begin
            dout[i] = ER2_TDO;
            JTDI = din[i];
            tick();
        end
        JSHIFT = 0; JCE2 = 0;
    endtask
    task automatic upd();
        JCE2 = 1; IP_ENABLE = 1; JUPDATE = 1;
        tick();
        JUPDATE = 0; JCE2 = 0;
    endtask
    task automatic op(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
        logic [41:0] o;
        scan({d, a, c}, o);
        check("cap_busy", o[0], 1'b0);
        check("cap_err", o[1], m_err);
        check("cap_addr", o[9:2], m_last);
        check("cap_data", o[41:10], m_rdata);
        upd();
        if (c == CMD_CLR) m_err = 0;
    endtask
    task automatic quiet_cmd();
        int seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (req) seen++;
            tick();
        end
        check("no_req", seen, 0);
        check("err", err, m_err);
    endtask
    // d: cycle after req rises on which ack pulses (0 = never); ovr_k: cycle of a repeated update (0 = none)
    task automatic run(input int d, input int ovr_k, input logic is_wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] rd);
        bit acked = (d >= 1 && d <= 16);
        int m = acked ? d : 16;
        int cnt = 0;
        bit stable = 1;
        bit probe = (ovr_k == 0 && m >= 2);
        check("req_start", req, 1'b1);
        check("busy_start", busy, 1'b1);
        check("we", we, is_wr);
        check("addr", addr, a);
        if (is_wr) check("wdata", wdata, wd);
        for (int k = 1; k <= 20; k++) begin
            if (req) cnt++;
            if (req && (addr !== a || we !== is_wr || (is_wr && wdata !== wd))) stable = 0;
            if (probe && k == 3) check("cap_busy_wait", ER2_TDO, 1'b1);
            ack = (k == d);
            rdata = (k == d) ? rd : $urandom;
            if (k == ovr_k) begin JCE2 = 1; IP_ENABLE = 1; JUPDATE = 1; end
            if (probe && k == 2) begin JCE2 = 1; IP_ENABLE = 1; end
            tick();
            ack = 0; JUPDATE = 0; JCE2 = 0;
        end
        check("req_cycles", cnt, m);
        check("bus_stable", stable, 1'b1);
        check("busy_end", busy, 1'b0);
        if (!acked || ovr_k != 0) m_err = 1;
        if (acked && !is_wr) m_rdata = rd;
        m_last = a;
        check("err", err, m_err);
    endtask
    initial begin
        logic [41:0] o;
        logic [7:0]  a;
        logic [31:0] wd, rd;
        int          d, ov, sel, same;
        tick(); tick();
        check("rst_req", req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_tdo", ER2_TDO, 1'b0);
        check("rst_bus", {we, addr, wdata}, 41'd0);
        JRSTN = 1;
        tick();
        op(CMD_WR, 8'h5A, 32'hDEADBEEF);
        run(3, 0, 1, 8'h5A, 32'hDEADBEEF, 32'h0);
        op(CMD_RD, 8'h10, 32'h0);
        run(2, 0, 0, 8'h10, 32'h0, 32'h12345678);
        op(CMD_RD, 8'h33, 32'h0);
        run(0, 0, 0, 8'h33, 32'h0, 32'hBAD0BAD0);
        op(CMD_CLR, 8'h00, 32'h0);
        quiet_cmd();
        op(CMD_WR, 8'h21, 32'hCAFEF00D);
        run(4, 4, 1, 8'h21, 32'hCAFEF00D, 32'h0);
        op(CMD_CLR, 8'h00, 32'h0);
        quiet_cmd();
        op(CMD_WR, 8'h22, 32'h0BADCAFE);
        run(5, 2, 1, 8'h22, 32'h0BADCAFE, 32'h0);
        op(CMD_CLR, 8'h00, 32'h0);
        quiet_cmd();
        same = 1;
        JCE2 = 1; IP_ENABLE = 0; JSHIFT = 1;
        wd = 32'hA5A5F00F;
        for (int i = 0; i < 42; i++) begin
            o = {wd, 8'h77, CMD_WR};
            JTDI = o[i];
            if (ER2_TDO !== 1'b1 || req !== 1'b0) same = 0;
            tick();
        end
        JSHIFT = 0; JUPDATE = 1;
        tick();
        JUPDATE = 0; JCE2 = 0;
        check("desel_tdo_hold", same, 1);
        check("desel_no_req", req, 1'b0);
        upd();
        quiet_cmd();
        op(CMD_WR, 8'h44, 32'h11112222);
        tick(); tick(); tick();
        check("midwait_req", req, 1'b1);
        JRSTN = 0;
        tick(); tick();
        check("rst2_req", req, 1'b0);
        check("rst2_busy", busy, 1'b0);
        check("rst2_err", err, 1'b0);
        check("rst2_tdo", ER2_TDO, 1'b0);
        JRSTN = 1;
        m_err = 0; m_last = '0; m_rdata = '0;
        scan({32'h0, 8'h0, CMD_NOP}, o);
        check("rst2_scan", o, 42'd0);
        upd();
        quiet_cmd();
        for (int t = 0; t < 30; t++) begin
            a = 8'($urandom); wd = $urandom; rd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                op(CMD_CLR, a, wd);
                quiet_cmd();
            end else if (sel == 1) begin
                op(CMD_NOP, a, wd);
                quiet_cmd();
            end else begin
                d = $urandom_range(0, 18);
                ov = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (d >= 1 && d <= 16) ? d : 16) : 0;
                op(sel[0] ? CMD_WR : CMD_RD, a, wd);
                run(d, ov, sel[0], a, wd, rd);
            end
        end
        op(CMD_NOP, 8'h0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
